// File: rtl/ror_sched_ctrl_if.sv
// ror_sched_ctrl_if: control, datapath and outlier-FIFO signals of the ROR scheduler.
interface ror_sched_ctrl_if #(
    parameter int CORE_NUMBER      = 2,
    parameter int DISTANCE_MODULES = 4,
    parameter int N                = 16,
    parameter int CNT_W            = 8
);
    logic start;
    logic [N-1:0] point_cloud_size;
    logic [CNT_W-1:0] min_neighbours;
    logic [N-1:0] target_pos;
    logic [N-1:0] feed_pos;
    logic feed_req;
    logic hit_valid;
    logic [CORE_NUMBER*DISTANCE_MODULES-1:0] hit;
    logic read_fifo;
    logic [N-1:0] outlier_pos_fifo;
    logic empty;
    logic full;
    logic [N-1:0] outlier_count;
    logic busy;
    logic done;
    modport master(
        output start, point_cloud_size, min_neighbours, hit_valid, hit, read_fifo,
        input target_pos, feed_pos, feed_req, outlier_pos_fifo, empty, full, outlier_count, busy, done
    );
    modport slave(
        input start, point_cloud_size, min_neighbours, hit_valid, hit, read_fifo,
        output target_pos, feed_pos, feed_req, outlier_pos_fifo, empty, full, outlier_count, busy, done
    );
endinterface

// File: rtl/ror_sched_ctrl.sv
// ror_sched_ctrl: radius-outlier-removal scheduler; sweeps target groups against neighbour chunks
// and queues targets with too few in-radius neighbours into a show-ahead outlier FIFO.
module ror_sched_ctrl #(
    parameter int CORE_NUMBER      = 2,
    parameter int DISTANCE_MODULES = 4,
    parameter int N                = 16,
    parameter int CNT_W            = 8,
    parameter int FIFO_DEPTH       = 32
) (
    input logic clock,
    input logic reset,
    ror_sched_ctrl_if.slave bus
);
    localparam int C = CORE_NUMBER;
    localparam int M = DISTANCE_MODULES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CI = C > 1 ? $clog2(C) : 1;
    localparam int PW = $clog2(M + 1);
    localparam int SW = CNT_W + PW;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, DONE} state_t;
    state_t state, state_n;

    logic [N-1:0] size, target_pos, feed_pos, outlier_count;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt [C];
    logic [CNT_W-1:0] cnt_n [C];
    logic [C-1:0] sat;
    logic [CI-1:0] ci;
    logic launch, resp, leave, group_end, need, last, advance, push, pop;
    logic [N-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ, occ_n;
    logic empty, full;

    // Per-core masked popcount; out-of-range cores count as satisfied so they never block early exit.
    for (genvar c = 0; c < C; c++) begin : g_core
        logic [N:0] t;
        logic [PW-1:0] pc;
        logic [SW-1:0] sum;
        assign t = {1'b0, target_pos} + (N+1)'(c);
        always_comb begin
            pc = '0;
            for (int m = 0; m < M; m++)
                pc = pc + PW'(bus.hit[c*M+m] && t != {1'b0, feed_pos} + (N+1)'(m)
                              && {1'b0, feed_pos} + (N+1)'(m) < {1'b0, size});
        end
        assign sum = SW'(cnt[c]) + SW'(pc);
        assign cnt_n[c] = sum >= SW'(thr) ? thr : sum[CNT_W-1:0];
        assign sat[c] = t >= {1'b0, size} || cnt_n[c] >= thr;
    end

    assign launch = bus.start && (state == IDLE || state == DONE);
    assign resp = state == WAIT && bus.hit_valid;
    assign leave = &sat || {1'b0, feed_pos} + (N+1)'(M) >= {1'b0, size};
    assign group_end = {1'b0, target_pos} + (N+1)'(C) >= {1'b0, size};
    assign need = cnt[ci] < thr;
    assign last = ci == CI'(C - 1) || {1'b0, target_pos} + (N+1)'(ci) + (N+1)'(1) >= {1'b0, size};
    assign advance = state == PUSH && !(need && full);
    assign push = state == PUSH && need && !full;
    assign pop = bus.read_fifo && !empty;
    assign occ_n = occ + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start) state_n = bus.point_cloud_size == '0 ? DONE : ISSUE;
            ISSUE:      state_n = WAIT;
            WAIT:       if (bus.hit_valid) state_n = leave ? PUSH : ISSUE;
            PUSH:       if (advance && last) state_n = group_end ? DONE : ISSUE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            size <= '0;
            thr <= '0;
            target_pos <= '0;
            feed_pos <= '0;
            outlier_count <= '0;
            ci <= '0;
            cnt <= '{default: '0};
        end else if (launch) begin
            size <= bus.point_cloud_size;
            thr <= bus.min_neighbours;
            target_pos <= '0;
            feed_pos <= '0;
            outlier_count <= '0;
            ci <= '0;
            cnt <= '{default: '0};
        end else if (resp) begin
            cnt <= cnt_n;
            ci <= '0;
            if (!leave) feed_pos <= feed_pos + N'(M);
        end else if (advance) begin
            if (push) outlier_count <= outlier_count + N'(1);
            if (last) begin
                target_pos <= target_pos + N'(C);
                feed_pos <= '0;
                ci <= '0;
                cnt <= '{default: '0};
            end else ci <= ci + CI'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            empty <= 1'b1;
            full <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            occ <= occ_n;
            empty <= occ_n == '0;
            full <= occ_n == (AW+1)'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= target_pos + N'(ci);

    assign bus.target_pos = target_pos;
    assign bus.feed_pos = feed_pos;
    assign bus.feed_req = state == ISSUE;
    assign bus.outlier_pos_fifo = mem[rd_ptr];
    assign bus.empty = empty;
    assign bus.full = full;
    assign bus.outlier_count = outlier_count;
    assign bus.busy = state == ISSUE || state == WAIT || state == PUSH;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_ror_sched_ctrl.sv
// tb_ror_sched_ctrl: randomized bench; a transaction-level model predicts every request
// position, every outlier in FIFO order and the final counts of each pass.
module tb_ror_sched_ctrl;
    localparam int C = 2, M = 4, N = 16, CW = 8, D = 4;
    logic clock = 0, reset = 1;
    ror_sched_ctrl_if #(.CORE_NUMBER(C), .DISTANCE_MODULES(M), .N(N), .CNT_W(CW)) bus ();
    ror_sched_ctrl #(.CORE_NUMBER(C), .DISTANCE_MODULES(M), .N(N), .CNT_W(CW), .FIFO_DEPTH(D))
        dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;
    int m_size = 0, m_thr = 0, m_tp = 0, m_fp = 0, m_out = 0, n_req = 0;
    int m_cnt [C];
    bit m_over = 1, outstanding = 0;
    int exp_q [$], got_q [$];
    int delay = 0, hit_mode = 0, rd_prob = 0, stray_en = 1;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One datapath response: credit in-range, non-self hits, then decide next chunk or group end.
    task automatic model_resp(input logic [C*M-1:0] h);
        bit all_sat = 1;
        for (int c = 0; c < C; c++) begin
            if (m_tp + c >= m_size) continue;
            for (int m = 0; m < M; m++)
                if (h[c*M+m] && m_fp + m < m_size && m_fp + m != m_tp + c && m_cnt[c] < m_thr) m_cnt[c]++;
            if (m_cnt[c] < m_thr) all_sat = 0;
        end
        if (all_sat || m_fp + M >= m_size) begin
            for (int c = 0; c < C; c++)
                if (m_tp + c < m_size && m_cnt[c] < m_thr) begin
                    exp_q.push_back(m_tp + c);
                    m_out++;
                end
            m_tp += C;
            m_fp = 0;
            m_cnt = '{default: 0};
            m_over = m_tp >= m_size;
        end else m_fp += M;
    endtask

    function automatic logic [C*M-1:0] gen_hit();
        logic [C*M-1:0] h = '0;
        case (hit_mode)
            1: h = '1;
            2: h = '0;
            3: for (int c = 0; c < C; c++)
                   for (int m = 0; m < M; m++)
                       if (m_tp + c == m_fp + m) h[c*M+m] = 1'b1;
            default: h = (C*M)'($urandom) & (C*M)'($urandom);
        endcase
        return h;
    endfunction

    // Datapath responder and per-cycle compare against the model.
    initial begin
        bus.hit_valid = 0;
        bus.hit = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.hit_valid = 0;
            if (reset) outstanding = 0;
            else if (outstanding) begin
                if (delay == 0) begin
                    bus.hit = gen_hit();
                    bus.hit_valid = 1;
                    model_resp(bus.hit);
                    outstanding = 0;
                end else delay--;
            end else if (stray_en != 0 && $urandom_range(7) == 0) begin
                bus.hit = (C*M)'($urandom);
                bus.hit_valid = 1;
            end
            @(negedge clock);
            if (!reset && bus.feed_req) begin
                n_req++;
                chk("req_expected", int'(m_over), 0);
                chk("req_single", int'(outstanding), 0);
                chk("target_pos", int'(bus.target_pos), m_tp);
                chk("feed_pos", int'(bus.feed_pos), m_fp);
                outstanding = 1;
                delay = int'($urandom_range(3));
            end
            if (!reset && bus.done && !bus.start) chk("done_when_model_over", int'(m_over), 1);
            if (!reset && bus.busy) chk("outlier_count_bounded", int'(int'(bus.outlier_count) <= m_out), 1);
            if (!reset) chk("full_empty_exclusive", int'(bus.full && bus.empty), 0);
        end
    end

    // FIFO reader: every pop is checked against the model's outlier order.
    initial begin
        bus.read_fifo = 0;
        forever begin
            @(posedge clock);
            #1;
            bus.read_fifo = !reset && int'($urandom_range(99)) < rd_prob;
            @(negedge clock);
            if (!reset && bus.read_fifo && !bus.empty) begin
                chk("fifo_has_model_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("outlier_pos_fifo", int'(bus.outlier_pos_fifo), exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got_q.push_back(int'(bus.outlier_pos_fifo));
            end
        end
    end

    task automatic start_pass(input int size, input int thr);
        m_size = size;
        m_thr = thr;
        m_tp = 0;
        m_fp = 0;
        m_out = 0;
        m_cnt = '{default: 0};
        m_over = size == 0;
        n_req = 0;
        bus.point_cloud_size = N'(size);
        bus.min_neighbours = CW'(thr);
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("busy_after_start", int'(bus.busy), int'(size != 0));
        chk("done_after_start", int'(bus.done), int'(size == 0));
    endtask

    task automatic drain();
        int k = 0;
        rd_prob = 100;
        while ((!bus.empty || exp_q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_empty", int'(bus.empty), 1);
        chk("drain_model_empty", exp_q.size(), 0);
    endtask

    task automatic end_pass(input int budget);
        int k = 0;
        while (!bus.done && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", int'(bus.done), 1);
        chk("busy_at_done", int'(bus.busy), 0);
        chk("outlier_count", int'(bus.outlier_count), m_out);
        drain();
    endtask

    initial begin
        int k;
        bus.start = 0;
        bus.point_cloud_size = '0;
        bus.min_neighbours = '0;
        tick(3);
        chk("rst_target_pos", int'(bus.target_pos), 0);
        chk("rst_feed_pos", int'(bus.feed_pos), 0);
        chk("rst_outlier_count", int'(bus.outlier_count), 0);
        chk("rst_feed_req", int'(bus.feed_req), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        reset = 0;
        tick();

        start_pass(0, 1);
        tick(4);
        chk("size0_done", int'(bus.done), 1);
        chk("size0_reqs", n_req, 0);
        chk("size0_empty", int'(bus.empty), 1);

        // all neighbours hit: every group exits after one request; stray start ignored
        hit_mode = 1;
        rd_prob = 100;
        start_pass(8, 1);
        tick(2);
        bus.start = 1;
        bus.point_cloud_size = N'(3);
        tick();
        bus.start = 0;
        end_pass(500);
        chk("allhit_reqs", n_req, 4);
        chk("allhit_outliers", int'(bus.outlier_count), 0);

        hit_mode = 2;
        got_q.delete();
        start_pass(8, 2);
        end_pass(500);
        chk("nohit_reqs", n_req, 8);
        chk("nohit_outliers", int'(bus.outlier_count), 8);
        chk("nohit_got_count", got_q.size(), 8);
        foreach (got_q[i]) chk("nohit_order", got_q[i], i);

        start_pass(6, 2);
        end_pass(500);
        chk("size6_reqs", n_req, 6);
        chk("size6_outliers", int'(bus.outlier_count), 6);

        hit_mode = 3;
        start_pass(6, 1);
        end_pass(500);
        chk("selfhit_reqs", n_req, 6);
        chk("selfhit_outliers", int'(bus.outlier_count), 6);

        hit_mode = 1;
        start_pass(6, 3);
        end_pass(500);
        chk("size6_allhit_reqs", n_req, 3);
        chk("size6_allhit_outliers", int'(bus.outlier_count), 0);

        // FIFO full stall, then a single pop lets exactly one more push through
        hit_mode = 2;
        rd_prob = 0;
        got_q.delete();
        start_pass(8, 2);
        tick(100);
        chk("stall_full", int'(bus.full), 1);
        chk("stall_busy", int'(bus.busy), 1);
        chk("stall_outlier_count", int'(bus.outlier_count), 4);
        chk("stall_reqs", n_req, 6);
        @(negedge clock);
        rd_prob = 100;
        @(negedge clock);
        rd_prob = 0;
        tick(3);
        chk("resume_outlier_count", int'(bus.outlier_count), 5);
        chk("resume_full", int'(bus.full), 1);
        chk("resume_got", got_q.size(), 1);
        rd_prob = 100;
        end_pass(500);
        chk("stall_got_count", got_q.size(), 8);
        foreach (got_q[i]) chk("stall_order", got_q[i], i);

        // reset while waiting for a response
        start_pass(16, 3);
        k = 0;
        while (!bus.feed_req && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("saw_req_before_reset", int'(bus.feed_req), 1);
        @(posedge clock);
        #1;
        reset = 1;
        tick();
        m_over = 1;
        exp_q.delete();
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_empty", int'(bus.empty), 1);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_outlier_count", int'(bus.outlier_count), 0);
        reset = 0;
        tick(6);
        chk("postrst_idle", int'(bus.busy), 0);
        chk("postrst_no_req", int'(bus.feed_req), 0);
        hit_mode = 0;
        start_pass(8, 1);
        end_pass(1000);

        for (int p = 0; p < 12; p++) begin
            rd_prob = int'($urandom_range(10, 100));
            start_pass(int'($urandom_range(20)), int'($urandom_range(5)));
            end_pass(3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
